serial_magnitude_comparator: RTL and testbench

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

---
 rtl/serial_magnitude_comparator.sv | 110 +++++++++++
 tb/tb_serial_magnitude_comparator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: scans one bit pair per cycle MSB-first and
// exits early on the first difference, with unsigned or two's-complement ordering.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             Eq,
  output logic             L
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               signed_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic               g_q;
  logic               eq_q;
  logic               l_q;

  logic               bit_a;
  logic               bit_b;
  logic               at_msb;
  logic               a_wins_d;

  assign bit_a  = a_q[idx_q];
  assign bit_b  = b_q[idx_q];
  assign at_msb = (idx_q == IDX_W'(WIDTH - 1));

  // A set sign bit makes a two's-complement operand the smaller one.
  assign a_wins_d = (at_msb && signed_q) ? bit_b : bit_a;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the operand registers are reset too, keeping the block
  // free of X after reset even though their value is don't-care in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      g_q      <= 1'b0;
      eq_q     <= 1'b0;
      l_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx_q    <= IDX_W'(WIDTH - 1);
            g_q      <= 1'b0;
            eq_q     <= 1'b0;
            l_q      <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (bit_a != bit_b) begin
            g_q     <= a_wins_d;
            l_q     <= !a_wins_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign G    = g_q;
  assign Eq   = eq_q;
  assign L    = l_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: vector table plus a sweep at
// WIDTH=8 and WIDTH=16, and hand-written protocol and reset-abort sequences.
module tb_serial_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sm8, busy8, done8, g8, eq8, l8;
  logic [7:0]  a8, b8;
  logic        start16, sm16, busy16, done16, g16, eq16, l16;
  logic [15:0] a16, b16;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          sm;
    bit          wide;
    logic [2:0]  exp_gel;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .signed_mode(sm8),
    .busy(busy8), .done(done8), .G(g8), .Eq(eq8), .L(l8)
  );

  serial_magnitude_comparator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .signed_mode(sm16),
    .busy(busy16), .done(done16), .G(g16), .Eq(eq16), .L(l16)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_gel(bit wide, logic [15:0] av, logic [15:0] bv, bit sm);
    logic [7:0] a_lo, b_lo;
    a_lo = av[7:0];
    b_lo = bv[7:0];
    if (wide) begin
      if (sm) return ($signed(av) > $signed(bv)) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001;
      return (av > bv) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001;
    end
    if (sm) return ($signed(a_lo) > $signed(b_lo)) ? 3'b100 : (a_lo == b_lo) ? 3'b010 : 3'b001;
    return (a_lo > b_lo) ? 3'b100 : (a_lo == b_lo) ? 3'b010 : 3'b001;
  endfunction

  function automatic int ref_lat(bit wide, logic [15:0] av, logic [15:0] bv);
    int w;
    w = wide ? 16 : 8;
    for (int i = w - 1; i >= 0; i--)
      if (av[i] != bv[i]) return (w - 1 - i) + 2;
    return w + 1;
  endfunction

  function automatic logic [2:0] gel8();
    return {g8, eq8, l8};
  endfunction

  // Launches one comparison, scrambles the inputs right after acceptance and
  // checks latency, result, busy/done exclusivity and result hold.
  task automatic run_cmp(input logic [15:0] av, input logic [15:0] bv, input bit sm,
                         input bit wide, input logic [2:0] exp_gel, input int exp_lat,
                         input string name);
    int   k;
    bit   seen;
    bit   scan_ok;
    logic [2:0] gel;
    @(negedge clk);
    if (wide) begin
      a16 = av; b16 = bv; sm16 = sm; start16 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm; start8 = 1'b1;
    end
    k = 0; seen = 1'b0; scan_ok = 1'b1;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start8 = 1'b0; start16 = 1'b0;
        a8 = ~a8; b8 = b8 + 8'd3; sm8 = ~sm8;
        a16 = ~a16; b16 = b16 + 16'd3; sm16 = ~sm16;
      end
      gel = wide ? {g16, eq16, l16} : gel8();
      if (wide ? done16 : done8) seen = 1'b1;
      else if (!(wide ? busy16 : busy8) || gel != 3'b000) scan_ok = 1'b0;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(k), 32'(exp_lat));
    check({name, "_gel"}, 32'(gel), 32'(exp_gel));
    check({name, "_scan_busy_zero_result"}, 32'(scan_ok), 32'd1);
    check({name, "_busy_at_done"}, 32'(wide ? busy16 : busy8), 32'd0);
    if (seen) begin
      @(negedge clk);
      gel = wide ? {g16, eq16, l16} : gel8();
      check({name, "_hold"}, 32'({(wide ? done16 : done8), gel}), 32'({1'b0, exp_gel}));
    end
  endtask

  initial begin
    int   k;
    int   done_cnt;
    bit   ok;

    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset_dut8", 32'({busy8, done8, g8, eq8, l8}), 32'd0);
    check("reset_dut16", 32'({busy16, done16, g16, eq16, l16}), 32'd0);
    rst = 1'b0;

    // Hand-computed vectors; gel = {G, Eq, L}.
    vecs.push_back('{16'h0006, 16'h0006, 1'b0, 1'b0, 3'b010, 9,  "u8_6_eq_6"});
    vecs.push_back('{16'h0008, 16'h0006, 1'b0, 1'b0, 3'b100, 6,  "u8_8_gt_6"});
    vecs.push_back('{16'h0080, 16'h0001, 1'b1, 1'b0, 3'b001, 2,  "s8_80_lt_01"});
    vecs.push_back('{16'h0080, 16'h0001, 1'b0, 1'b0, 3'b100, 2,  "u8_80_gt_01"});
    vecs.push_back('{16'h00FF, 16'h0000, 1'b1, 1'b0, 3'b001, 2,  "s8_m1_lt_0"});
    vecs.push_back('{16'h007F, 16'h0080, 1'b1, 1'b0, 3'b100, 2,  "s8_7f_gt_80"});
    vecs.push_back('{16'h007F, 16'h0080, 1'b0, 1'b0, 3'b001, 2,  "u8_7f_lt_80"});
    vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b0, 3'b100, 9,  "u8_lsb_diff"});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 1'b1, 3'b001, 2,  "s16_min_lt_max"});
    vecs.push_back('{16'hFFFF, 16'h8000, 1'b1, 1'b1, 3'b100, 3,  "s16_m1_gt_min"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 3'b010, 17, "u16_ffff_eq"});

    foreach (vecs[i])
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].wide,
              vecs[i].exp_gel, vecs[i].exp_lat, vecs[i].name);

    // Sweep: 8-bit values 6..10 and 16-bit corner values in both modes.
    for (int m = 0; m < 2; m++)
      for (int x = 6; x <= 10; x++)
        for (int y = 6; y <= 10; y++)
          run_cmp(16'(x), 16'(y), m[0], 1'b0, ref_gel(1'b0, 16'(x), 16'(y), m[0]),
                  ref_lat(1'b0, 16'(x), 16'(y)), $sformatf("sweep8_m%0d_%0d_%0d", m, x, y));
    begin
      logic [15:0] corners [3];
      corners[0] = 16'h8000; corners[1] = 16'h7FFF; corners[2] = 16'hFFFF;
      for (int m = 0; m < 2; m++)
        for (int x = 0; x < 3; x++)
          for (int y = 0; y < 3; y++)
            run_cmp(corners[x], corners[y], m[0], 1'b1,
                    ref_gel(1'b1, corners[x], corners[y], m[0]),
                    ref_lat(1'b1, corners[x], corners[y]),
                    $sformatf("sweep16_m%0d_%0h_%0h", m, corners[x], corners[y]));
    end

    // Start during scan is ignored; start in the done cycle is accepted.
    @(negedge clk);
    a8 = 8'd6; b8 = 8'd6; sm8 = 1'b0; start8 = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (i == 3) start8 = 1'b1;
      if (i == 4) start8 = 1'b0;
      if (i < 9 && done8) done_cnt++;
    end
    check("proto_no_early_done", 32'(done_cnt), 32'd0);
    check("proto_done_t9", 32'({done8, gel8()}), 32'({1'b1, 3'b010}));
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("proto_restart_t10", 32'({busy8, done8, gel8()}), 32'({1'b1, 1'b0, 3'b000}));
    k = 1;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("proto_restart_latency", 32'(k), 32'd9);
    check("proto_restart_gel", 32'(gel8()), 32'(3'b010));

    // Reset in the middle of a scan aborts it with no done pulse.
    @(negedge clk);
    a8 = 8'd6; b8 = 8'd6; sm8 = 1'b0; start8 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (i == 4) rst = 1'b1;
    end
    rst = 1'b0;
    check("abort_t5_outputs", 32'({busy8, done8, g8, eq8, l8}), 32'd0);
    ok = 1'b1;
    for (int i = 6; i <= 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) ok = 1'b0;
    end
    check("abort_no_done_through_t15", 32'(ok), 32'd1);

    run_cmp(16'h0003, 16'h0005, 1'b0, 1'b0, 3'b001, 7, "after_abort_u8_3_lt_5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
